// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings and responder state type
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      RESP_OKAY  = 2'b00,
      RESP_ERROR = 2'b01
   } hresp_e;

   typedef enum logic [2:0] {
      SIZE_BYTE = 3'd0,
      SIZE_HALF = 3'd1,
      SIZE_WORD = 3'd2
   } hsize_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ERR1,
      ST_ERR2
   } slv_state_e;

   localparam logic [1:0] HRESP_OKAY  = RESP_OKAY;
   localparam logic [1:0] HRESP_ERROR = RESP_ERROR;

endpackage

// File: rtl/ahb_slv_mem_array.sv
// rtl/ahb_slv_mem_array.sv - DEPTH x 32 storage, byte-strobed write, async read
module ahb_slv_mem_array
   import ahb_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [3:0]        wstrb,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH];

   // Clear every word on reset; otherwise update only the strobed byte lanes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
               mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite responder with wait states, ERROR response and internal memory
module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [1:0]  htrans,
   input  logic        hreadyin,
   input  logic [31:0] hwdata,
   output logic        hreadyout,
   output logic [1:0]  hresp,
   output logic [31:0] hrdata
);

   localparam int         ADDR_W = $clog2(DEPTH);
   localparam logic [2:0] WS     = 3'(WAIT_STATES);

   slv_state_e        state;
   logic [2:0]        cnt;
   logic [ADDR_W+1:0] addr_q;
   logic              write_q;
   logic [2:0]        size_q;
   // An OKAY data phase (non-error transfer) is in progress
   logic              dp_ok;

   logic              accept;
   logic              addr_err;
   logic              size_err;
   logic              align_err;
   logic              xfer_err;
   logic              we;
   logic [3:0]        strb;
   logic [31:0]       rdata;
   logic              unused_ok;

   // Bursts are handled beat by beat, so the burst type carries no information here
   assign unused_ok = ^hburst;

   assign accept    = hsel && hreadyin &&
                      (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
   assign addr_err  = haddr[31:ADDR_W+2] != '0;
   assign size_err  = hsize > SIZE_WORD;
   assign align_err = (hsize == SIZE_HALF && haddr[0]) ||
                      (hsize == SIZE_WORD && haddr[1:0] != 2'b00);
   assign xfer_err  = addr_err || size_err || align_err;

   // Responder FSM: wait-state countdown, two-cycle ERROR, pipelined address acceptance
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state     <= ST_IDLE;
         cnt       <= 3'd0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         size_q    <= SIZE_BYTE;
         dp_ok     <= 1'b0;
         hreadyout <= 1'b1;
         hresp     <= HRESP_OKAY;
      end else if (state == ST_ERR1) begin
         state     <= ST_ERR2;
         hreadyout <= 1'b1;
      end else if (state == ST_WAIT && cnt != 3'd0) begin
         cnt <= cnt - 3'd1;
         if (cnt == 3'd1) begin
            hreadyout <= 1'b1;
         end
      end else if (accept) begin
         // Final data-phase cycle (or idle): take the next address phase
         addr_q  <= haddr[ADDR_W+1:0];
         write_q <= hwrite;
         size_q  <= hsize;
         if (xfer_err) begin
            state     <= ST_ERR1;
            dp_ok     <= 1'b0;
            hreadyout <= 1'b0;
            hresp     <= HRESP_ERROR;
         end else if (WS != 3'd0) begin
            state     <= ST_WAIT;
            cnt       <= WS;
            dp_ok     <= 1'b1;
            hreadyout <= 1'b0;
            hresp     <= HRESP_OKAY;
         end else begin
            state     <= ST_IDLE;
            dp_ok     <= 1'b1;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
         end
      end else begin
         state     <= ST_IDLE;
         dp_ok     <= 1'b0;
         hreadyout <= 1'b1;
         hresp     <= HRESP_OKAY;
      end
   end

   // Writes commit at the edge closing the last data-phase cycle
   assign we = dp_ok && hreadyout && write_q;

   // Little-endian byte-lane strobes from the captured size and low address bits
   always_comb begin
      strb = 4'b0000;
      case (size_q)
         SIZE_BYTE: strb = 4'b0001 << addr_q[1:0];
         SIZE_HALF: strb = addr_q[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: strb = 4'b1111;
         default:   strb = 4'b0000;
      endcase
      if (!we) begin
         strb = 4'b0000;
      end
   end

   ahb_slv_mem_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (hclk),
      .rst   (hreset),
      .addr  (addr_q[ADDR_W+1:2]),
      .wstrb (strb),
      .wdata (hwdata),
      .rdata (rdata)
   );

   // Read data is driven only during an OKAY read data phase; the bus is quiet otherwise
   assign hrdata = (dp_ok && !write_q) ? rdata : 32'h0;

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-Lite responder with an internal word-addressed memory. It completes NONSEQ/SEQ transfers with a programmable number of wait states, and returns the two-cycle ERROR response for illegal transfers. It answers the bus driven by the testbench AHB master agent and is the reference slave for agent self-checks and for bridge-less bring-up. Single-slave system: hreadyin is the bus HREADY fed back from hreadyout.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words, power of two; ADDR_W = log2(DEPTH).
- WAIT_STATES, 1: hreadyout-low cycles inserted before each OKAY data phase; range 0..7.

Ports:
- hclk, input, 1: clock; all logic on the rising edge.
- hreset, input, 1: asynchronous reset, active-high.
- hsel, input, 1: slave select.
- haddr, input, 32: byte address.
- hwrite, input, 1: 1 = write, 0 = read.
- hsize, input, 3: 0 = byte, 1 = half, 2 = word.
- hburst, input, 3: burst type; ignored, each beat is handled independently.
- htrans, input, 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hreadyin, input, 1: bus ready; the address phase is sampled only when it is 1.
- hwdata, input, 32: write data, valid in the data phase.
- hreadyout, output, 1: data phase complete.
- hresp, output, 2: 00 OKAY, 01 ERROR; 10 and 11 are never driven.
- hrdata, output, 32: read data, valid when hreadyout = 1 in a read data phase.

## Operation
- Transfer accepted: when hsel & hreadyin & htrans[1] at a rising edge. The block then captures addr, write, size and the error flag.
- Non-transfers: IDLE, BUSY, or hsel = 0 get a zero-wait OKAY and no memory access.
- Error conditions:
  - haddr[31:ADDR_W+2] != 0;
  - hsize > 2;
  - misalignment: half with haddr[0] = 1, or word with haddr[1:0] != 0.
- State machine, states IDLE, WAIT, ERR1, ERR2:
  - IDLE: hreadyout = 1. On an accepted transfer: if erroneous, go to ERR1. Else if WAIT_STATES > 0, go to WAIT and load cnt = WAIT_STATES. Else complete in the next cycle (data phase with hreadyout = 1), then re-evaluate.
  - WAIT: hreadyout = 0 and cnt decrements each cycle. When cnt reaches 0, drive hreadyout = 1 and OKAY for one cycle; that is the last data-phase cycle.
  - ERR1: hreadyout = 0, hresp = ERROR. Always moves to ERR2.
  - ERR2: hreadyout = 1, hresp = ERROR. Accepts the next address phase like IDLE.
- Pipelining: a new address phase is accepted in the final data-phase cycle (hreadyout = 1) of the previous transfer.
- Write commit: at the edge ending the final data-phase cycle. Only the addressed byte lanes (little-endian) take hwdata.
  - byte: lane haddr[1:0];
  - half: lanes {haddr[1],0} and {haddr[1],1};
  - word: all four lanes.
- Reads: hrdata = mem[addr_q[ADDR_W+1:2]], full word. The master extracts the lanes.
- Bus quiet values: hrdata = 0 outside a read data phase and during error responses.
- Errored transfers never modify memory.
- Read after write to the same word, back-to-back: the read returns the new data, because the write commits before the read's data phase.

## Timing
- Reset values: hreadyout = 1, hresp = 00, hrdata = 0, state IDLE, cnt 0, all memory words 0.
- Reset mid-transfer: the transfer is aborted and a pending write is not committed.
- OKAY latency: the data phase lasts WAIT_STATES + 1 cycles after the address-phase edge.
- ERROR latency: exactly 2 data-phase cycles, with no wait states, regardless of WAIT_STATES.
- The master must hold hwdata stable for the whole data phase. hwdata is sampled only in the final cycle.
- BUSY inside a burst, arriving while the previous beat's data phase completes: next cycle is OKAY, no access, counter untouched.
- Master cancels after ERR1 by driving IDLE in ERR2's address phase: the block accepts IDLE and returns to IDLE state.

## Structure
- ahb_pkg holds:
  - htrans_e, hresp_e and hsize_e enums;
  - the slave state enum (IDLE/WAIT/ERR1/ERR2);
  - HRESP_OKAY/HRESP_ERROR constants.
- Sub-module ahb_slv_mem_array holds the storage: DEPTH x 32, 4-bit byte write strobe, asynchronous read port, reset to 0.
- Strobe generation and the FSM live in ahb_slave_mem.

## Test plan
- Reset release: hreadyout = 1, hresp = 00, hrdata = 0. Read of 0x0 with WAIT_STATES = 1 returns 0x00000000 after one hreadyout-low cycle.
- Word write then read:
  - Stimulus: write 0xDEADBEEF to 0x10, then a back-to-back NONSEQ read of 0x10.
  - Response: the read returns 0xDEADBEEF; each data phase is 2 cycles.
- Byte and half writes:
  - Stimulus: to word 0x20 (initially 0), write byte 0xAA at 0x21, then half 0x1234 at 0x22.
  - Response: a word read of 0x20 returns 0x1234AA00.
- Errors, each with hreadyout 0 then 1 while hresp = 01 in both cycles; a follow-up read of word 0 shows it unchanged:
  - write to 0x400 with DEPTH = 256;
  - word access at 0x02;
  - hsize = 3.
- INCR4 burst with BUSY inserted after beat 2, WAIT_STATES = 0: the BUSY gets a 1-cycle OKAY, and all 4 beats are written to 0x40..0x4C.
- Reset mid-write: assert hreset during the WAIT cycle of a write of 0x55 to 0x8. Afterwards, a read of 0x8 returns 0.
